// File: rtl/pretrig_capture_buffer.sv
// pretrig_capture_buffer: continuous-record ring buffer that, on a trigger, rewinds by a clamped
// pre-trigger length and streams history plus live samples, dropping the oldest sample on overrun.
module pretrig_capture_buffer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 24000,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  sample_valid,
  input  logic                  trigger,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] pretrig_len,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  streaming,
  output logic                  overrun
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] MAX_N = CW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fill_q, fill_d, count_q, count_d, req, n, wr_ext;
  logic overrun_q, overrun_d, data_valid_q, rd, wr;
  logic [DATA_WIDTH-1:0] data_out_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
    return p == LAST ? '0 : p + ADDR_WIDTH'(1);
  endfunction
  always_comb begin
    wr = sample_valid;
    rd = state_q == STREAM && rd_en && count_q != '0;
    wr_ext = {1'b0, wr_ptr_q};
    // rewind is limited by what has actually been recorded and by one less than the ring size
    req = {1'b0, pretrig_len} < fill_q ? {1'b0, pretrig_len} : fill_q;
    n = req < MAX_N ? req : MAX_N;
    state_d = state_q;
    wr_ptr_d = wr ? inc(wr_ptr_q) : wr_ptr_q;
    fill_d = (wr && fill_q != DEPTH_C) ? fill_q + CW'(1) : fill_q;
    rd_ptr_d = rd ? inc(rd_ptr_q) : rd_ptr_q;
    count_d = count_q;
    overrun_d = overrun_q;
    if (state_q == IDLE) begin
      count_d = '0;
      if (trigger && !stop) begin
        state_d = STREAM;
        rd_ptr_d = ADDR_WIDTH'(wr_ext >= n ? wr_ext - n : wr_ext + DEPTH_C - n);
        count_d = n + CW'(wr);
        overrun_d = 1'b0;
      end
    end else if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (wr && !rd && count_q == DEPTH_C) begin
      rd_ptr_d = inc(rd_ptr_q);
      overrun_d = 1'b1;
    end else begin
      count_d = count_q + CW'(wr) - CW'(rd);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q <= '0;
      count_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q <= fill_d;
      count_q <= count_d;
      overrun_q <= overrun_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr_q] <= data_in;
  end
  // read-first: a read and write to the same slot returns the stored (older) sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
      data_valid_q <= 1'b0;
    end else begin
      data_valid_q <= rd;
      if (rd) data_out_q <= mem[rd_ptr_q];
    end
  end
  assign data_out = data_out_q;
  assign data_valid = data_valid_q;
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == DEPTH_C;
  assign streaming = state_q == STREAM;
  assign overrun = overrun_q;
endmodule
